pipe_skid_wb: RTL and testbench
===============================

# pipe_skid_wb

Parametrised successor of the MEM/WB pipeline register. It carries one register-file write request (enable, address, data) from the memory stage to write-back through a two-entry skid buffer. A valid/ready handshake on both sides lets write-back back-pressure without a combinational ready path, and a synchronous flush drops every in-flight entry. Writes to register 0 are optionally squashed at entry.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- ZERO_SUPPRESS, 1, when 1 an accepted entry with regw_addr_i == 0 is stored with write = 0 and data = 0

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  block can accept this cycle; driven directly from a register
- write_i  input  1  register-write enable of incoming entry
- regw_addr_i  input  ADDR_W  destination register
- regw_data_i  input  DATA_W  write data
- out_valid  output  1  head entry present
- out_ready  input  1  downstream consumes head this cycle
- write_o  output  1  head write enable, gated by out_valid
- regw_addr_o  output  ADDR_W  head address
- regw_data_o  output  DATA_W  head data
- count  output  2  occupancy, 0..2

## Operation
- Storage: main slot (drives outputs) and skid slot. Each slot holds write, addr and data; validity is tracked by the state.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- States:
  - EMPTY: count 0, in_ready 1, out_valid 0.
  - ONE: count 1, in_ready 1, out_valid 1.
  - FULL: count 2, in_ready 0, out_valid 1.
- Transitions:
  - EMPTY: accept -> ONE, main <= in.
  - ONE: accept & consume -> ONE, main <= in. Accept only -> FULL, skid <= in. Consume only -> EMPTY.
  - FULL: consume -> ONE, main <= skid. Otherwise hold.
- Priority: reset > flush > handshake.
  - flush forces EMPTY. Any accept in the same cycle is discarded.
  - Slot contents are not cleared by flush.
- Zero suppression: with ZERO_SUPPRESS=1 and an incoming addr of 0, the stored write is 0, the stored data is 0 and the addr is stored as 0. The entry still occupies a slot and still handshakes.
- write_o = out_valid & main.write. regw_addr_o/regw_data_o show main contents, which hold their last value when out_valid = 0.
- No reordering: entries leave in acceptance order.

## Timing
- Reset values: state EMPTY, count 0, in_ready 1, out_valid 0, write_o 0, regw_addr_o 0, regw_data_o 0. Both slots are cleared to 0.
- Latency: an entry accepted at edge N appears on the outputs after edge N, i.e. in cycle N+1.
- Throughput: 1 entry/cycle while out_ready = 1. The skid slot is never used in that case.
- in_ready is a registered output: it deasserts the cycle after the block enters FULL and reasserts the cycle after the first consume from FULL. It never depends combinationally on out_ready.
- out_ready may change freely. The head must stay stable while out_valid = 1 and out_ready = 0.
- Reset or flush asserted mid-stream: the outputs show out_valid = 0 and write_o = 0 from the next cycle on. Entries offered in the flush cycle are lost.

## Test plan
- Reset, then in_valid=1 write=1 addr=3 data=0xDEADBEEF with out_ready=1 -> next cycle: out_valid=1, write_o=1, addr 3, data 0xDEADBEEF, count=1.
- Stream 4 entries back-to-back with out_ready=1 -> outputs follow inputs delayed 1 cycle; in_ready stays 1; count never exceeds 1.
- Drive out_ready=0 and offer A, B, C -> A and B accepted, count=2, in_ready=0, C held upstream. Then out_ready=1 -> A, B, C emerge in order with no duplicates or gaps.
- ZERO_SUPPRESS=1, offer write=1 addr=0 data=0x1234 -> out_valid=1, write_o=0, data 0. With ZERO_SUPPRESS=0 -> write_o=1, data 0x1234.
- FULL state, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, write_o=0, in_ready=1; the offered entry never appears.
- Assert reset while FULL with out_ready=1 -> next cycle all outputs at reset values; no entry is consumed or emitted afterward.

Source files
------------

// File: rtl/pipe_skid_wb.sv
// pipe_skid_wb: MEM/WB pipeline register with a two-entry skid buffer.
// Carries one register-file write request (write, addr, data) per entry from
// the memory stage to write-back. Upstream sees a registered in_ready, so the
// write-back stage can stall without a combinational ready path back into MEM.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   flush                   synchronous discard of all held entries
//   in_valid / in_ready     upstream handshake (in_ready is a flop output)
//   write_i, regw_addr_i,
//   regw_data_i             incoming write request
//   out_valid / out_ready   downstream handshake
//   write_o, regw_addr_o,
//   regw_data_o             head write request (write_o gated by out_valid)
//   count                   occupancy, 0..2
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | no entries held; in_ready 1, out_valid 0
// S_ONE   | main slot valid; in_ready 1, out_valid 1
// S_FULL  | main and skid slots valid; in_ready 0, out_valid 1
module pipe_skid_wb #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 5,
   parameter int ZERO_SUPPRESS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] regw_addr_i,
   input  logic [DATA_W-1:0] regw_data_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              write_o,
   output logic [ADDR_W-1:0] regw_addr_o,
   output logic [DATA_W-1:0] regw_data_o,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic              in_ready_q;
   logic              main_write_q;
   logic [ADDR_W-1:0] main_addr_q;
   logic [DATA_W-1:0] main_data_q;
   logic              skid_write_q;
   logic [ADDR_W-1:0] skid_addr_q;
   logic [DATA_W-1:0] skid_data_q;

   logic              accept;
   logic              consume;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid_in;

   // Writes to r0 are architecturally dead, so they travel as bubbles that
   // still occupy a slot and keep the handshake sequence intact.
   logic              suppress;
   logic              in_write;
   logic [DATA_W-1:0] in_data;

   assign suppress = (ZERO_SUPPRESS != 0) && (regw_addr_i == '0);
   assign in_write = suppress ? 1'b0 : write_i;
   assign in_data  = suppress ? '0 : regw_data_i;

   assign out_valid = (state_q != S_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid & in_ready_q;
   assign consume   = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d      = S_ONE;
                  load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && consume) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d      = S_FULL;
                  load_skid_in = 1'b1;
               end else if (consume) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (consume) begin
                  state_d        = S_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_EMPTY;
         in_ready_q   <= 1'b1;
         main_write_q <= 1'b0;
         main_addr_q  <= '0;
         main_data_q  <= '0;
         skid_write_q <= 1'b0;
         skid_addr_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         // Registered ready: computed from the next state so it tracks
         // FULL exactly one cycle later without looking at out_ready.
         in_ready_q <= (state_d != S_FULL);
         if (load_main_in) begin
            main_write_q <= in_write;
            main_addr_q  <= regw_addr_i;
            main_data_q  <= in_data;
         end else if (load_main_skid) begin
            main_write_q <= skid_write_q;
            main_addr_q  <= skid_addr_q;
            main_data_q  <= skid_data_q;
         end
         if (load_skid_in) begin
            skid_write_q <= in_write;
            skid_addr_q  <= regw_addr_i;
            skid_data_q  <= in_data;
         end
      end
   end

   assign write_o     = out_valid & main_write_q;
   assign regw_addr_o = main_addr_q;
   assign regw_data_o = main_data_q;
   assign count       = state_q;

endmodule

// File: tb/tb_pipe_skid_wb.sv
module tb_pipe_skid_wb;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, write_i, out_ready;
   logic [4:0]  regw_addr_i;
   logic [31:0] regw_data_i;

   logic        in_ready, out_valid, write_o;
   logic [4:0]  regw_addr_o;
   logic [31:0] regw_data_o;
   logic [1:0]  count;

   logic        nz_in_ready, nz_out_valid, nz_write_o;
   logic [4:0]  nz_regw_addr_o;
   logic [31:0] nz_regw_data_o;
   logic [1:0]  nz_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   pipe_skid_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1)) u_dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .write_i(write_i), .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data_o(regw_data_o),
      .count(count)
   );

   pipe_skid_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(0)) u_dut_nz (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(nz_in_ready),
      .write_i(write_i), .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
      .out_valid(nz_out_valid), .out_ready(out_ready),
      .write_o(nz_write_o), .regw_addr_o(nz_regw_addr_o), .regw_data_o(nz_regw_data_o),
      .count(nz_count)
   );

   // Advance one clock; inputs and checks happen 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic w, input logic [4:0] a, input logic [31:0] d);
      in_valid    = 1'b1;
      write_i     = w;
      regw_addr_i = a;
      regw_data_i = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; write_i = 1'b0;
      regw_addr_i = '0; regw_data_i = '0; out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_o: got %b expected 0", write_o); end
      n_checks++; if (regw_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", regw_addr_o); end
      n_checks++; if (regw_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", regw_data_o); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      offer(1'b1, 5'd3, 32'hDEADBEEF);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
      n_checks++; if (write_o !== 1'b1) begin n_fail++; $display("FAIL single_write_o: got %b expected 1", write_o); end
      n_checks++; if (regw_addr_o !== 5'd3) begin n_fail++; $display("FAIL single_addr: got %0d expected 3", regw_addr_o); end
      n_checks++; if (regw_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", regw_data_o); end
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
      n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL single_drain_write_o: got %b expected 0", write_o); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  ea;
      logic [31:0] ed;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ea = 5'(4 + i);
         ed = 32'h0000_0100 + 32'(i);
         offer(i[0], ea, ed);
         step();
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
         n_checks++; if (write_o !== i[0]) begin n_fail++; $display("FAIL b2b_write_o[%0d]: got %b expected %b", i, write_o, i[0]); end
         n_checks++; if (regw_addr_o !== ea) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, regw_addr_o, ea); end
         n_checks++; if (regw_data_o !== ed) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, regw_data_o, ed); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
         n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count); end
      end
      in_valid = 1'b0;
      step();
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      offer(1'b1, 5'd10, 32'hAAAA_0001);
      step();
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_count_a: got %0d expected 1", count); end
      offer(1'b1, 5'd11, 32'hBBBB_0002);
      step();
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count_ab: got %0d expected 2", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
      n_checks++; if (regw_addr_o !== 5'd10) begin n_fail++; $display("FAIL bp_head_a: got %0d expected 10", regw_addr_o); end
      offer(1'b1, 5'd12, 32'hCCCC_0003);
      step();
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count_hold: got %0d expected 2", count); end
      n_checks++; if (regw_data_o !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_head_stable: got %h expected aaaa0001", regw_data_o); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_hold: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      step();
      n_checks++; if (regw_addr_o !== 5'd11) begin n_fail++; $display("FAIL bp_head_b_addr: got %0d expected 11", regw_addr_o); end
      n_checks++; if (regw_data_o !== 32'hBBBB_0002) begin n_fail++; $display("FAIL bp_head_b_data: got %h expected bbbb0002", regw_data_o); end
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_count_b: got %0d expected 1", count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (regw_addr_o !== 5'd12) begin n_fail++; $display("FAIL bp_head_c_addr: got %0d expected 12", regw_addr_o); end
      n_checks++; if (regw_data_o !== 32'hCCCC_0003) begin n_fail++; $display("FAIL bp_head_c_data: got %h expected cccc0003", regw_data_o); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_c_valid: got %b expected 1", out_valid); end
      step();
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL bp_drained: got %0d expected 0", count); end
   endtask

   task automatic test_zero_suppress();
      out_ready = 1'b1;
      offer(1'b1, 5'd0, 32'h0000_1234);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zs_valid: got %b expected 1", out_valid); end
      n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL zs_write_o: got %b expected 0", write_o); end
      n_checks++; if (regw_data_o !== 32'd0) begin n_fail++; $display("FAIL zs_data: got %h expected 0", regw_data_o); end
      n_checks++; if (nz_write_o !== 1'b1) begin n_fail++; $display("FAIL nzs_write_o: got %b expected 1", nz_write_o); end
      n_checks++; if (nz_regw_data_o !== 32'h0000_1234) begin n_fail++; $display("FAIL nzs_data: got %h expected 1234", nz_regw_data_o); end
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      offer(1'b1, 5'd20, 32'hD0D0_0004);
      step();
      offer(1'b1, 5'd21, 32'hE0E0_0005);
      step();
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL fl_prefill: got %0d expected 2", count); end
      flush = 1'b1;
      offer(1'b1, 5'd22, 32'hF0F0_0006);
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL fl_count: got %0d expected 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b expected 0", out_valid); end
      n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL fl_write_o: got %b expected 0", write_o); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (regw_addr_o !== 5'd20) begin n_fail++; $display("FAIL fl_addr_hold: got %0d expected 20", regw_addr_o); end
      out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_ghost: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      offer(1'b1, 5'd25, 32'h1111_0007);
      step();
      offer(1'b1, 5'd26, 32'h2222_0008);
      step();
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL rf_prefill: got %0d expected 2", count); end
      out_ready = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL rf_count: got %0d expected 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b expected 0", out_valid); end
      n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL rf_write_o: got %b expected 0", write_o); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rf_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (regw_addr_o !== 5'd0) begin n_fail++; $display("FAIL rf_addr: got %0d expected 0", regw_addr_o); end
      n_checks++; if (regw_data_o !== 32'd0) begin n_fail++; $display("FAIL rf_data: got %h expected 0", regw_data_o); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_after_valid: got %b expected 0", out_valid); end
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL rf_after_count: got %0d expected 0", count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_zero_suppress();
      test_flush();
      test_reset_full();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
